// File: rtl/ppc_fetch_queue.sv
`default_nettype none
// ppc_fetch_queue: doubleword instruction fetch with a DEPTH-entry in-order queue to decode.
// Revision 1.0 - first release.
module ppc_fetch_queue #(
   parameter int                ADDR_W   = 64,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       memReqValid,
   input  logic                       memReqReady,
   output logic [ADDR_W-4:0]          memReqAddr,
   input  logic                       memRspValid,
   input  logic [63:0]                memRspData,
   output logic                       instValid,
   input  logic                       instReady,
   output logic [31:0]                inst,
   output logic [ADDR_W-1:0]          instPc,
   input  logic                       redirectValid,
   input  logic [ADDR_W-1:0]          redirectPc,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]       count_q, count_d;
   logic [31:0]         inst_mem_q [DEPTH];
   logic [ADDR_W-1:0]   pc_mem_q   [DEPTH];

   logic                w_pop;
   logic [CW:0]         w_free;
   logic                w_req_fire;
   logic                w_push;
   logic                w_odd;
   logic [1:0]          w_npush;
   logic [PW-1:0]       w_wr_nx;

   assign w_pop  = (count_q != '0) & instReady;
   // Free slots include this cycle's pop so a draining queue can re-request one cycle earlier.
   assign w_free = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, w_pop};

   assign memReqValid = rst_n & (state_q == S_IDLE) & (w_free >= (CW+1)'(2));
   assign memReqAddr  = fetch_pc_q[ADDR_W-1:3];
   assign w_req_fire  = memReqValid & memReqReady;

   assign w_odd   = fetch_pc_q[2];
   assign w_push  = (state_q == S_WAIT) & memRspValid & ~redirectValid;
   assign w_npush = w_push ? (w_odd ? 2'd1 : 2'd2) : 2'd0;
   assign w_wr_nx = wr_q + PW'(1);

   assign instValid = (count_q != '0);
   assign inst      = inst_mem_q[rd_q];
   assign instPc    = pc_mem_q[rd_q];
   assign count     = count_q;

   always_comb begin
      count_d    = count_q + CW'(w_npush) - CW'(w_pop);
      wr_d       = wr_q + PW'(w_npush);
      rd_d       = rd_q + PW'(w_pop);
      fetch_pc_d = fetch_pc_q;
      if (w_push) begin
         fetch_pc_d = fetch_pc_q + (w_odd ? ADDR_W'(4) : ADDR_W'(8));
      end
      if (redirectValid) begin
         count_d    = '0;
         wr_d       = '0;
         rd_d       = '0;
         fetch_pc_d = {redirectPc[ADDR_W-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q    <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         fetch_pc_q <= RESET_PC;
      end else begin
         count_q    <= count_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   // Word at offset 0 is the most significant half of the big-endian doubleword.
   always_ff @(posedge clk) begin
      if (w_push) begin
         if (w_odd) begin
            inst_mem_q[wr_q] <= memRspData[31:0];
            pc_mem_q[wr_q]   <= fetch_pc_q;
         end else begin
            inst_mem_q[wr_q]    <= memRspData[63:32];
            pc_mem_q[wr_q]      <= fetch_pc_q;
            inst_mem_q[w_wr_nx] <= memRspData[31:0];
            pc_mem_q[w_wr_nx]   <= fetch_pc_q + ADDR_W'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else if (redirectValid) begin
         // Anything still in flight after this edge must be thrown away when it returns.
         case (state_q)
            S_IDLE:            state_q <= w_req_fire  ? S_DISCARD : S_IDLE;
            S_WAIT, S_DISCARD: state_q <= memRspValid ? S_IDLE    : S_DISCARD;
            default:           state_q <= S_IDLE;
         endcase
      end else begin
         case (state_q)
            S_IDLE:    if (w_req_fire)  state_q <= S_WAIT;
            S_WAIT:    if (memRspValid) state_q <= S_IDLE;
            S_DISCARD: if (memRspValid) state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ppc_fetch_queue.sv
`default_nettype none
// tb_ppc_fetch_queue: directed vectors against hand-computed fetch/queue results.
module tb_ppc_fetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        memReqValid, memReqReady, memRspValid;
   logic [60:0] memReqAddr;
   logic [63:0] memRspData;
   logic        instValid, instReady;
   logic [31:0] inst;
   logic [63:0] instPc;
   logic        redirectValid;
   logic [63:0] redirectPc;
   logic [2:0]  count;

   logic        b_memReqValid, b_memReqReady, b_memRspValid;
   logic [60:0] b_memReqAddr;
   logic [63:0] b_memRspData;
   logic        b_instValid;
   logic [31:0] b_inst;
   logic [63:0] b_instPc;
   logic [2:0]  b_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ppc_fetch_queue #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'd0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqAddr(memReqAddr),
      .memRspValid(memRspValid), .memRspData(memRspData),
      .instValid(instValid), .instReady(instReady), .inst(inst), .instPc(instPc),
      .redirectValid(redirectValid), .redirectPc(redirectPc), .count(count)
   );

   ppc_fetch_queue #(.ADDR_W(64), .DEPTH(4), .RESET_PC(64'd4)) u_dut_pc4 (
      .clk(clk), .rst_n(rst_n),
      .memReqValid(b_memReqValid), .memReqReady(b_memReqReady), .memReqAddr(b_memReqAddr),
      .memRspValid(b_memRspValid), .memRspData(b_memRspData),
      .instValid(b_instValid), .instReady(1'b0), .inst(b_inst), .instPc(b_instPc),
      .redirectValid(1'b0), .redirectPc(64'd0), .count(b_count)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] word_at(input logic [63:0] pc);
      if (pc == 64'd0) return 32'h3800_0005;
      if (pc == 64'd4) return 32'h3860_0041;
      return 32'hA000_0000 | {4'h0, pc[27:0]};
   endfunction

   function automatic logic [63:0] dword_at(input logic [60:0] a);
      logic [63:0] pc;
      pc = {a, 3'b000};
      return {word_at(pc), word_at(pc + 64'd4)};
   endfunction

   initial begin
      rst_n = 1'b0; memReqReady = 1'b0; memRspValid = 1'b0; memRspData = '0;
      instReady = 1'b0; redirectValid = 1'b0; redirectPc = '0;
      b_memReqReady = 1'b0; b_memRspValid = 1'b0; b_memRspData = '0;
      step(); step();
      #1;
      check_eq("rst_count", 64'(count), 64'd0);
      check_eq("rst_instValid", 64'(instValid), 64'd0);
      check_eq("rst_reqValid", 64'(memReqValid), 64'd0);

      // Basic fetch of doubleword 0, one-cycle memory latency
      rst_n = 1'b1; memReqReady = 1'b1;
      #1;
      check_eq("first_reqValid", 64'(memReqValid), 64'd1);
      check_eq("first_reqAddr", 64'(memReqAddr), 64'd0);
      step();
      memRspValid = 1'b1; memRspData = 64'h3800_0005_3860_0041;
      #1;
      check_eq("wait_reqValid", 64'(memReqValid), 64'd0);
      step();
      memRspValid = 1'b0;
      #1;
      check_eq("first_inst", 64'(inst), 64'h3800_0005);
      check_eq("first_pc", instPc, 64'd0);
      check_eq("first_count", 64'(count), 64'd2);
      check_eq("second_reqAddr", 64'(memReqAddr), 64'd1);

      // Fill the queue with decode stalled
      step();
      memRspValid = 1'b1; memRspData = dword_at(61'd1);
      step();
      memRspValid = 1'b0;
      #1;
      check_eq("full_count", 64'(count), 64'd4);
      check_eq("full_reqValid", 64'(memReqValid), 64'd0);
      instReady = 1'b1;
      #1;
      check_eq("pop1_reqValid", 64'(memReqValid), 64'd0);
      step();
      #1;
      check_eq("pop1_count", 64'(count), 64'd3);
      check_eq("pop1_inst", 64'(inst), 64'h3860_0041);
      check_eq("pop1_pc", instPc, 64'd4);
      check_eq("pop2_reqValid", 64'(memReqValid), 64'd1);
      check_eq("pop2_reqAddr", 64'(memReqAddr), 64'd2);
      step();
      instReady = 1'b0;
      #1;
      check_eq("pop2_count", 64'(count), 64'd2);
      check_eq("pop2_pc", instPc, 64'd8);
      check_eq("pop2_inst", 64'(inst), 64'hA000_0008);

      // Redirect while a request is outstanding
      redirectValid = 1'b1; redirectPc = 64'h103;
      step();
      redirectValid = 1'b0;
      #1;
      check_eq("redir_count", 64'(count), 64'd0);
      check_eq("redir_instValid", 64'(instValid), 64'd0);
      check_eq("discard_reqValid", 64'(memReqValid), 64'd0);
      memRspValid = 1'b1; memRspData = 64'hDEAD_BEEF_DEAD_BEEF;
      step();
      memRspValid = 1'b0;
      #1;
      check_eq("stale_count", 64'(count), 64'd0);
      check_eq("redir_reqValid", 64'(memReqValid), 64'd1);
      check_eq("redir_reqAddr", 64'(memReqAddr), 64'h20);
      step();
      memRspValid = 1'b1; memRspData = dword_at(61'h20);
      step();
      memRspValid = 1'b0;
      #1;
      check_eq("redir_inst", 64'(inst), 64'hA000_0100);
      check_eq("redir_pc", instPc, 64'h100);
      check_eq("redir_fill", 64'(count), 64'd2);

      // Redirect coinciding with response and pop: nothing is kept, no discard state
      step();
      memRspValid = 1'b1; memRspData = dword_at(61'h21);
      instReady = 1'b1; redirectValid = 1'b1; redirectPc = 64'h200;
      step();
      memRspValid = 1'b0; instReady = 1'b0; redirectValid = 1'b0;
      #1;
      check_eq("same_count", 64'(count), 64'd0);
      check_eq("same_instValid", 64'(instValid), 64'd0);
      check_eq("same_reqValid", 64'(memReqValid), 64'd1);
      check_eq("same_reqAddr", 64'(memReqAddr), 64'h40);
      step();
      memRspValid = 1'b1; memRspData = dword_at(61'h40);
      step();
      memRspValid = 1'b0;
      #1;
      check_eq("same_pc", instPc, 64'h200);
      instReady = 1'b1;
      step();
      instReady = 1'b0;
      #1;
      check_eq("second_word_pc", instPc, 64'h204);
      check_eq("second_word_inst", 64'(inst), 64'hA000_0204);

      // Reset while a request is outstanding; the late response is ignored
      memReqReady = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1; memRspValid = 1'b1; memRspData = 64'h1234_5678_9ABC_DEF0;
      #1;
      check_eq("rstw_reqValid", 64'(memReqValid), 64'd1);
      check_eq("rstw_reqAddr", 64'(memReqAddr), 64'd0);
      step();
      memRspValid = 1'b0;
      #1;
      check_eq("rstw_count", 64'(count), 64'd0);
      check_eq("rstw_still_idle", 64'(memReqValid), 64'd1);
      memReqReady = 1'b1;
      step();
      memReqReady = 1'b0; memRspValid = 1'b1; memRspData = dword_at(61'd0);
      step();
      memRspValid = 1'b0;
      #1;
      check_eq("rstw_inst", 64'(inst), 64'h3800_0005);
      check_eq("rstw_count2", 64'(count), 64'd2);

      // RESET_PC = 4 instance: odd half only, then next doubleword
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; b_memReqReady = 1'b1;
      #1;
      check_eq("pc4_reqValid", 64'(b_memReqValid), 64'd1);
      check_eq("pc4_reqAddr", 64'(b_memReqAddr), 64'd0);
      step();
      b_memReqReady = 1'b0; b_memRspValid = 1'b1; b_memRspData = 64'h1111_1111_2222_2222;
      step();
      b_memRspValid = 1'b0;
      #1;
      check_eq("pc4_count", 64'(b_count), 64'd1);
      check_eq("pc4_inst", 64'(b_inst), 64'h2222_2222);
      check_eq("pc4_pc", b_instPc, 64'd4);
      check_eq("pc4_next_addr", 64'(b_memReqAddr), 64'd1);
      check_eq("pc4_next_valid", 64'(b_memReqValid), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
